// File: rtl/axi_ctrl_pkg.sv
// Shared types and constants for the command arbiter and its neighbours.
// Holds the arbiter FSM encoding and the 2-bit AXI response codes.
package axi_ctrl_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_cmd_arbiter_if.sv
// Bundle of requester-side and downstream-side signals around the command arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface axi_cmd_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb;
   logic [NUM_REQ*8-1:0]          req_len;
   logic [NUM_REQ-1:0]            req_rvalid;
   logic [NUM_REQ-1:0]            req_rready;
   logic [DATA_WIDTH-1:0]         req_rdata;
   logic [1:0]                    req_resp;
   logic [NUM_REQ-1:0]            req_done;

   logic                          m_cmd_valid;
   logic                          m_cmd_ready;
   logic                          m_cmd_write;
   logic [ADDR_WIDTH-1:0]         m_cmd_addr;
   logic [DATA_WIDTH-1:0]         m_cmd_wdata;
   logic [STRB_WIDTH-1:0]         m_cmd_wstrb;
   logic [7:0]                    m_cmd_len;
   logic [DATA_WIDTH-1:0]         m_cmd_rdata;
   logic                          m_cmd_rvalid;
   logic                          m_cmd_rready;
   logic [1:0]                    m_cmd_resp;
   logic                          m_cmd_done;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, req_len, req_rready,
      output req_ready, req_rvalid, req_rdata, req_resp, req_done,
      output m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_wdata, m_cmd_wstrb, m_cmd_len,
      output m_cmd_rready,
      input  m_cmd_ready, m_cmd_rdata, m_cmd_rvalid, m_cmd_resp, m_cmd_done
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, req_len, req_rready,
      input  req_ready, req_rvalid, req_rdata, req_resp, req_done,
      input  m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_wdata, m_cmd_wstrb, m_cmd_len,
      input  m_cmd_rready,
      output m_cmd_ready, m_cmd_rdata, m_cmd_rvalid, m_cmd_resp, m_cmd_done
   );

endinterface

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ... modulo NUM_REQ
// and returns the first requesting index.
module axi_rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any
);

   logic [IDX_W-1:0] idx;

   // The !any guard makes the earliest index in the rotated order win.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ command requesters onto one downstream
// command port; one transaction is owned end to end before the next arbitration.
module axi_cmd_arbiter
   import axi_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int IDX_W     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   axi_cmd_arbiter_if.slave   bus,
   output logic [IDX_W-1:0]   grant_id,
   output logic               busy
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("axi_cmd_arbiter: NUM_REQ must be in 2..16");
   end

   arb_state_t         state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [NUM_REQ-1:0] grant_oh;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
   logic [STRB_WIDTH-1:0] wstrb_arr [NUM_REQ];
   logic [7:0]            len_arr   [NUM_REQ];

   // Unpack the flat per-requester buses so the mux below indexes by grant_id.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_arr[i] = bus.req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
      assign len_arr[i]   = bus.req_len[i*8 +: 8];
   end

   axi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (bus.req_valid),
      .ptr    (last_grant),
      .winner (pick_idx),
      .any    (pick_any)
   );

   // last_grant only advances on completion, so an abandoned transaction
   // leaves the rotation where it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         grant_id   <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_id <= pick_idx;
                  state    <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (bus.m_cmd_ready) begin
                  state <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (bus.m_cmd_done) begin
                  last_grant <= grant_id;
                  state      <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign grant_oh      = NUM_REQ'(1) << grant_id;
   assign busy          = (state != ARB_IDLE);
   assign bus.req_rdata = bus.m_cmd_rdata;
   assign bus.req_resp  = bus.m_cmd_resp;

   // Everything routed to or from the owner is gated by state, so
   // downstream activity outside WAIT never leaks through.
   always_comb begin
      bus.m_cmd_valid  = 1'b0;
      bus.m_cmd_write  = 1'b0;
      bus.m_cmd_addr   = '0;
      bus.m_cmd_wdata  = '0;
      bus.m_cmd_wstrb  = '0;
      bus.m_cmd_len    = '0;
      bus.m_cmd_rready = 1'b0;
      bus.req_ready    = '0;
      bus.req_rvalid   = '0;
      bus.req_done     = '0;
      if (state == ARB_ISSUE) begin
         bus.m_cmd_valid = 1'b1;
         bus.m_cmd_write = bus.req_write[grant_id];
         bus.m_cmd_addr  = addr_arr[grant_id];
         bus.m_cmd_wdata = wdata_arr[grant_id];
         bus.m_cmd_wstrb = wstrb_arr[grant_id];
         bus.m_cmd_len   = len_arr[grant_id];
         bus.req_ready   = grant_oh & {NUM_REQ{bus.m_cmd_ready}};
      end
      if (state == ARB_WAIT) begin
         bus.m_cmd_rready = bus.req_rready[grant_id];
         bus.req_rvalid   = grant_oh & {NUM_REQ{bus.m_cmd_rvalid}};
         bus.req_done     = grant_oh & {NUM_REQ{bus.m_cmd_done}};
      end
   end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed bench for axi_cmd_arbiter: a grant-order vector table plus
// hand-written read, delayed-write and mid-transaction reset sequences.
module tb_axi_cmd_arbiter;
   import axi_ctrl_pkg::*;

   localparam int NUM_REQ    = 4;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_W      = 2;

   typedef struct {
      logic [NUM_REQ-1:0] valid;
      logic [IDX_W-1:0]   exp_grant;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [IDX_W-1:0] grant_id;
   logic             busy;
   int               checks = 0;
   int               errors = 0;
   vec_t             vecs [12];

   axi_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   axi_cmd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NUM_REQ-1:0] onehot(input int i);
      return NUM_REQ'(1) << i;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] exp_addr(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h100;
   endfunction

   task automatic setup_fields();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_write[i]                             = ((i % 2) == 1);
         bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]     = exp_addr(i);
         bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH]    = 32'hD0D0_0000 + 32'(i);
         bus.req_wstrb[i*STRB_WIDTH +: STRB_WIDTH]    = STRB_WIDTH'(i + 1);
         bus.req_len[i*8 +: 8]                        = 8'(i);
      end
   endtask

   task automatic clear_inputs();
      bus.req_valid    = '0;
      bus.req_rready   = '0;
      bus.m_cmd_ready  = 1'b0;
      bus.m_cmd_rvalid = 1'b0;
      bus.m_cmd_rdata  = '0;
      bus.m_cmd_resp   = RESP_OKAY;
      bus.m_cmd_done   = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One complete transaction: request, accept, done; checks latency and routing.
   task automatic apply_stimulus(input int k, input vec_t v);
      int g;
      g = int'(v.exp_grant);
      bus.req_valid = v.valid;
      #1;
      check_output($sformatf("v%0d_idle_no_cmd", k), 64'(bus.m_cmd_valid), 64'(0));
      tick();
      #1;
      check_output($sformatf("v%0d_cmd_valid", k), 64'(bus.m_cmd_valid), 64'(1));
      check_output($sformatf("v%0d_grant", k), 64'(grant_id), 64'(g));
      check_output($sformatf("v%0d_addr", k), 64'(bus.m_cmd_addr), 64'(exp_addr(g)));
      check_output($sformatf("v%0d_len", k), 64'(bus.m_cmd_len), 64'(g));
      check_output($sformatf("v%0d_ready_low", k), 64'(bus.req_ready), 64'(0));
      bus.m_cmd_ready = 1'b1;
      #1;
      check_output($sformatf("v%0d_ready", k), 64'(bus.req_ready), 64'(onehot(g)));
      tick();
      bus.m_cmd_ready = 1'b0;
      bus.req_valid   = '0;
      bus.m_cmd_done  = 1'b1;
      #1;
      check_output($sformatf("v%0d_done", k), 64'(bus.req_done), 64'(onehot(g)));
      check_output($sformatf("v%0d_busy_wait", k), 64'(busy), 64'(1));
      tick();
      bus.m_cmd_done = 1'b0;
      #1;
      check_output($sformatf("v%0d_busy_idle", k), 64'(busy), 64'(0));
   endtask

   logic [DATA_WIDTH-1:0] beat_data;

   initial begin
      vecs[0]  = '{4'b1111, 2'd0};
      vecs[1]  = '{4'b1111, 2'd1};
      vecs[2]  = '{4'b1111, 2'd2};
      vecs[3]  = '{4'b1111, 2'd3};
      vecs[4]  = '{4'b0100, 2'd2};
      vecs[5]  = '{4'b0101, 2'd0};
      vecs[6]  = '{4'b0101, 2'd2};
      vecs[7]  = '{4'b1000, 2'd3};
      vecs[8]  = '{4'b0011, 2'd0};
      vecs[9]  = '{4'b1010, 2'd1};
      vecs[10] = '{4'b1010, 2'd3};
      vecs[11] = '{4'b0110, 2'd1};

      setup_fields();
      apply_reset();
      #1;
      check_output("rst_busy", 64'(busy), 64'(0));
      check_output("rst_grant", 64'(grant_id), 64'(0));
      check_output("rst_cmd_valid", 64'(bus.m_cmd_valid), 64'(0));
      check_output("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check_output("rst_req_done", 64'(bus.req_done), 64'(0));

      for (int k = 0; k < 12; k++) begin
         apply_stimulus(k, vecs[k]);
      end

      // Read from requester 1, four beats, with stray downstream activity in ISSUE.
      setup_fields();
      bus.req_write[1]   = 1'b0;
      bus.req_len[15:8]  = 8'd3;
      apply_reset();
      bus.req_valid  = 4'b0010;
      bus.req_rready = 4'b0010;
      tick();
      bus.m_cmd_rvalid = 1'b1;
      bus.m_cmd_done   = 1'b1;
      #1;
      check_output("rd_grant", 64'(grant_id), 64'(1));
      check_output("rd_write", 64'(bus.m_cmd_write), 64'(0));
      check_output("rd_len", 64'(bus.m_cmd_len), 64'(3));
      check_output("rd_issue_no_rvalid", 64'(bus.req_rvalid), 64'(0));
      check_output("rd_issue_no_rready", 64'(bus.m_cmd_rready), 64'(0));
      check_output("rd_issue_no_done", 64'(bus.req_done), 64'(0));
      tick();
      bus.m_cmd_rvalid = 1'b0;
      bus.m_cmd_done   = 1'b0;
      #1;
      check_output("rd_still_issue", 64'(bus.m_cmd_valid), 64'(1));
      bus.m_cmd_ready = 1'b1;
      tick();
      bus.m_cmd_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         beat_data        = 32'hCAFE_0000 + 32'(b * 17);
         bus.m_cmd_rvalid = 1'b1;
         bus.m_cmd_rdata  = beat_data;
         #1;
         check_output($sformatf("rd_beat%0d_rvalid", b), 64'(bus.req_rvalid), 64'(4'b0010));
         check_output($sformatf("rd_beat%0d_rdata", b), 64'(bus.req_rdata), 64'(beat_data));
         check_output($sformatf("rd_beat%0d_rready", b), 64'(bus.m_cmd_rready), 64'(1));
         tick();
      end
      bus.m_cmd_rvalid = 1'b0;
      bus.m_cmd_done   = 1'b1;
      #1;
      check_output("rd_gap_rvalid", 64'(bus.req_rvalid), 64'(0));
      check_output("rd_done", 64'(bus.req_done), 64'(4'b0010));
      tick();
      bus.m_cmd_done = 1'b0;
      #1;
      check_output("rd_done_once", 64'(bus.req_done), 64'(0));
      check_output("rd_idle", 64'(busy), 64'(0));

      // Write from requester 3 with acceptance held off for five cycles.
      setup_fields();
      bus.req_wstrb[15:12] = 4'hF;
      apply_reset();
      bus.req_valid = 4'b1000;
      tick();
      for (int c = 0; c < 5; c++) begin
         if (c == 2) bus.req_valid = '0;
         #1;
         check_output($sformatf("wr_hold%0d_valid", c), 64'(bus.m_cmd_valid), 64'(1));
         check_output($sformatf("wr_hold%0d_wdata", c), 64'(bus.m_cmd_wdata), 64'(32'hD0D0_0003));
         check_output($sformatf("wr_hold%0d_ready", c), 64'(bus.req_ready), 64'(0));
         tick();
      end
      bus.m_cmd_ready = 1'b1;
      #1;
      check_output("wr_accept_ready", 64'(bus.req_ready), 64'(4'b1000));
      check_output("wr_write", 64'(bus.m_cmd_write), 64'(1));
      check_output("wr_wstrb", 64'(bus.m_cmd_wstrb), 64'(4'hF));
      tick();
      bus.m_cmd_ready = 1'b0;
      bus.m_cmd_resp  = RESP_SLVERR;
      bus.m_cmd_done  = 1'b1;
      #1;
      check_output("wr_done", 64'(bus.req_done), 64'(4'b1000));
      check_output("wr_resp", 64'(bus.req_resp), 64'(2'b10));
      tick();
      bus.m_cmd_done = 1'b0;

      // Reset while the owner (requester 2) is in WAIT.
      setup_fields();
      apply_reset();
      bus.req_valid = 4'b0100;
      tick();
      bus.m_cmd_ready = 1'b1;
      tick();
      bus.m_cmd_ready  = 1'b0;
      bus.req_valid    = '0;
      bus.req_rready   = 4'b0100;
      bus.m_cmd_rvalid = 1'b1;
      #1;
      check_output("rw_in_wait", 64'(bus.req_rvalid), 64'(4'b0100));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_output("rw_busy", 64'(busy), 64'(0));
      check_output("rw_grant", 64'(grant_id), 64'(0));
      check_output("rw_rvalid", 64'(bus.req_rvalid), 64'(0));
      check_output("rw_rready", 64'(bus.m_cmd_rready), 64'(0));
      check_output("rw_cmd_valid", 64'(bus.m_cmd_valid), 64'(0));
      bus.m_cmd_rvalid = 1'b0;
      bus.m_cmd_done   = 1'b1;
      #1;
      check_output("rw_late_done", 64'(bus.req_done), 64'(0));
      tick();
      bus.m_cmd_done = 1'b0;
      #1;
      check_output("rw_late_idle", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_cmd_arbiter.md
AXI_CMD_ARBITER -- requirements
Module: axi_cmd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 Parameter ADDR_WIDTH, default 32: command address width.
REQ-003 Parameter DATA_WIDTH, default 32: data width; STRB_WIDTH = DATA_WIDTH/8; IDX_W = $clog2(NUM_REQ).
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: reset is synchronous and active-high.
REQ-006 Port req_valid / req_ready, input / output, NUM_REQ each: per-requester command handshake.
REQ-007 Ports req_write (NUM_REQ), req_addr (NUM_REQ*ADDR_WIDTH), req_wdata (NUM_REQ*DATA_WIDTH), req_wstrb (NUM_REQ*STRB_WIDTH), req_len (NUM_REQ*8), all inputs: per-requester command fields, packed with requester i at slice i.
REQ-008 Ports req_rvalid (output, NUM_REQ) and req_rready (input, NUM_REQ): per-requester read-data handshake.
REQ-009 Ports req_rdata (output, DATA_WIDTH) and req_resp (output, 2): broadcast to all requesters, qualified by req_rvalid/req_done.
REQ-010 Port req_done, output, NUM_REQ: one-cycle completion pulse to the granted requester.
REQ-011 Ports m_cmd_valid (out, 1), m_cmd_ready (in, 1), m_cmd_write (out, 1), m_cmd_addr (out, ADDR_WIDTH), m_cmd_wdata (out, DATA_WIDTH), m_cmd_wstrb (out, STRB_WIDTH), m_cmd_len (out, 8): downstream master command port.
REQ-012 Ports m_cmd_rdata (in, DATA_WIDTH), m_cmd_rvalid (in, 1), m_cmd_rready (out, 1), m_cmd_resp (in, 2): downstream read data and response.
REQ-013 Port m_cmd_done, input, 1: one-cycle pulse from the master when the last read beat or the write response is accepted.
REQ-014 Ports grant_id (output, IDX_W) and busy (output, 1): current owner and "not IDLE" status.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT.
REQ-016 IDLE: if any req_valid bit is set, select the winner round-robin, register it in grant_id, and go to ISSUE; otherwise stay in IDLE.
REQ-017 Round-robin priority order: last_grant+1, last_grant+2, ..., wrapping modulo NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 has top priority after reset.
REQ-018 ISSUE: drive m_cmd_valid=1 with the fields of requester grant_id; set req_ready[grant_id] = m_cmd_ready combinationally; on m_cmd_valid&&m_cmd_ready go to WAIT.
REQ-019 WAIT: m_cmd_rready = req_rready[grant_id]; req_rvalid[grant_id] = m_cmd_rvalid; other req_rvalid bits are 0; req_rdata = m_cmd_rdata and req_resp = m_cmd_resp at all times.
REQ-020 WAIT: on m_cmd_done, pulse req_done[grant_id] for that cycle, set last_grant<=grant_id, and go to IDLE.
REQ-021 m_cmd_done in IDLE or ISSUE is ignored; m_cmd_rvalid outside WAIT is not forwarded and m_cmd_rready=0.
REQ-022 Latency: req_valid rising in IDLE at cycle N gives m_cmd_valid at N+1; after done, the next grant's m_cmd_valid is at the earliest 2 cycles later (one IDLE arbitration cycle).
REQ-023 Requests arriving during ISSUE/WAIT wait; no preemption; grant_id stays stable from IDLE exit to WAIT exit.
REQ-024 A requester deasserting req_valid in ISSUE is a protocol violation; the block keeps m_cmd_valid asserted until accepted.
REQ-025 Only one requester is granted per arbitration, so at most one bit of req_ready, req_rvalid and req_done is set in any cycle.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 Synchronous reset: state=IDLE, grant_id=0, last_grant=NUM_REQ-1; all outputs 0 (m_cmd_* data fields are don't-care).
REQ-028 Reset asserted mid-transaction abandons it with no req_done; any downstream completion after reset is ignored per REQ-021.

Structure
REQ-029 Shared package axi_ctrl_pkg holds the arb_state_t enum and the RESP_OKAY/EXOKAY/SLVERR/DECERR 2-bit constants.
REQ-030 The round-robin pick lives in combinational sub-module axi_rr_pick (inputs req vector and pointer; outputs winner index and any).

Verification
REQ-031 After reset, req_valid=4'b1111 held for 4 transactions -> grant order 0,1,2,3.
REQ-032 After a grant to 2, req_valid=4'b0101 -> next grant 0, then 2.
REQ-033 Read from req 1 with len=3 -> 4 beats reach only req_rvalid[1] with m_cmd_rdata values intact; req_done[1] pulses once on m_cmd_done.
REQ-034 Write from req 3, m_cmd_ready delayed 5 cycles -> req_ready[3] asserts exactly on the accept cycle and m_cmd_valid is stable; req_done[3] with req_resp=2'b10 when m_cmd_resp=SLVERR.
REQ-035 rst asserted in WAIT -> next cycle busy=0 and all outputs 0; a later m_cmd_done pulse produces no req_done.
